// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding and well-known scancodes.
// Used by the receiver and by the downstream key-matrix decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
    localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign valid = (cnt != '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign pop   = valid & ready;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign count = cnt;
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a scancode FIFO on a valid/ready port.
// Optional partial-frame timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          kbd_clk,
    input  logic                          kbd_dat,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    logic [FILTER_LEN-1:0] filt;
    logic                  clk_prev;
    logic                  strobe;

    rx_state_e state, state_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sr, sr_n;
    logic       par, par_n;
    logic       push;
    logic       perr_set;
    logic       ferr_set;
    logic       drop;
    logic       to_hit;

    // Hysteresis: a level is accepted only once every sample agrees.
    always_ff @(posedge clk) begin
        if (res) begin
            filt     <= '1;
            clk_prev <= 1'b1;
        end else begin
            filt <= {filt[FILTER_LEN-2:0], kbd_clk};
            if (&filt)
                clk_prev <= 1'b1;
            else if (filt == '0)
                clk_prev <= 1'b0;
        end
    end

    assign strobe = clk_prev & (filt == '0);

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (res || strobe || state == RX_IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Fires on the edge where the count would reach TIMEOUT_CYCLES-1.
    assign to_hit = (state != RX_IDLE) && !strobe &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 2));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state <= RX_IDLE;
            idx   <= '0;
            sr    <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            sr    <= sr_n;
            par   <= par_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sr_n     = sr;
        par_n    = par;
        push     = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (strobe) begin
            unique case (state)
                RX_IDLE: begin
                    if (!kbd_dat) begin
                        state_n = RX_DATA;
                        idx_n   = '0;
                    end
                end
                RX_DATA: begin
                    sr_n[idx] = kbd_dat;
                    idx_n     = idx + 1'b1;
                    if (idx == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_n   = kbd_dat;
                    state_n = RX_STOP;
                end
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (!kbd_dat)
                        ferr_set = 1'b1;
                    else if (!(^sr ^ par))
                        perr_set = 1'b1;
                    else
                        push = 1'b1;
                end
            endcase
        end else if (to_hit) begin
            state_n  = RX_IDLE;
            ferr_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= perr_set;
            frame_err  <= ferr_set;
            overflow   <= drop;
        end
    end

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .din   (sr),
        .ready (rx_ready),
        .dout  (rx_data),
        .valid (rx_valid),
        .count (rx_count),
        .drop  (drop)
    );

endmodule
